// File: rtl/sys_defs.sv
// Shared definitions for the branch tag allocator: tag mask type and FSM states.
package sys_defs;

    localparam int B_MASK_WIDTH = 4;

    typedef logic [B_MASK_WIDTH-1:0] B_MASK;

    typedef enum logic {
        BT_RUN     = 1'b0,
        BT_RECOVER = 1'b1
    } BTAG_STATE_E;

endpackage

// File: rtl/btag_pick_lowest.sv
// Combinational one-hot picker: returns the lowest set bit of the available mask (0 if none).
module btag_pick_lowest #(
    parameter int W = 4
) (
    input  logic [W-1:0] avail_i,
    output logic [W-1:0] pick_o
);

    // Two's-complement trick isolates the least significant set bit.
    assign pick_o = avail_i & (~avail_i + W'(1));

endmodule

// File: rtl/branch_tag_allocator.sv
// Branch tag allocator: grants one-hot branch-mask tags to dispatch (lowest free index first),
// frees them on resolve, and squashes dependent tags plus stalls dispatch on a mispredict.
// Optional feature macro BTAG_PERF_EN adds saturating performance counters as output ports.
module branch_tag_allocator #(
    parameter int B_MASK_WIDTH   = sys_defs::B_MASK_WIDTH,
    parameter int DISPATCH_WIDTH = 2,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]         disp_req_cnt,
    output logic [$clog2(DISPATCH_WIDTH+1)-1:0]         disp_grant_cnt,
    output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0] disp_tags,
    output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0] disp_dep_masks,
    output logic [B_MASK_WIDTH-1:0]                     cur_b_mask,
    input  logic                                        resolve_valid,
    input  logic [B_MASK_WIDTH-1:0]                     resolve_tag,
    input  logic                                        resolve_mispred,
    output logic [B_MASK_WIDTH-1:0]                     b_mm_out,
    output logic [B_MASK_WIDTH-1:0]                     squash_mask,
    output logic                                        restore_valid,
    output logic                                        recovering,
    output logic [$clog2(B_MASK_WIDTH+1)-1:0]           free_count
`ifdef BTAG_PERF_EN
    ,
    output logic [31:0]                                 perf_allocs,
    output logic [31:0]                                 perf_mispreds,
    output logic [31:0]                                 perf_stall_cycles
`endif
);

    import sys_defs::*;

    localparam int GW = $clog2(DISPATCH_WIDTH + 1);
    localparam int FW = $clog2(B_MASK_WIDTH + 1);
    localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    logic [B_MASK_WIDTH-1:0]                     live_q, live_d;
    logic [B_MASK_WIDTH-1:0][B_MASK_WIDTH-1:0]   dep_q, dep_d;
    logic [B_MASK_WIDTH-1:0]                     squash_q, squash_d;
    logic                                        restore_q, restore_d;
    BTAG_STATE_E                                 state_q, state_d;
    logic [CW-1:0]                               cnt_q, cnt_d;
    logic [FW-1:0]                               free_q, free_d;

    logic                                        res_onehot, res_hit, mispred_hit, stall;
    logic [B_MASK_WIDTH-1:0]                     kill, granted_all;
    logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0] avail, pick;

    function automatic logic [FW-1:0] popcnt(input logic [B_MASK_WIDTH-1:0] v);
        logic [FW-1:0] n;
        n = '0;
        for (int i = 0; i < B_MASK_WIDTH; i++) n = n + FW'(v[i]);
        return n;
    endfunction

    // A resolve only counts if it names exactly one tag that is currently allocated.
    assign res_onehot  = (resolve_tag != '0) && ((resolve_tag & (resolve_tag - B_MASK_WIDTH'(1))) == '0);
    assign res_hit     = resolve_valid && res_onehot && ((resolve_tag & live_q) != '0);
    assign mispred_hit = res_hit && resolve_mispred;
    assign stall       = mispred_hit || (state_q == BT_RECOVER);
    assign b_mm_out    = res_hit ? resolve_tag : '0;
    assign cur_b_mask  = live_q & ~b_mm_out;

    // Freed-this-cycle tags stay excluded: only tags free in registered state are offered.
    assign avail[0] = ~live_q;
    for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_pick
        btag_pick_lowest #(.W(B_MASK_WIDTH)) u_pick (
            .avail_i (avail[k]),
            .pick_o  (pick[k])
        );
        if (k + 1 < DISPATCH_WIDTH) begin : g_chain
            assign avail[k+1] = avail[k] & ~pick[k];
        end
    end

    // Grant slots in order; each slot depends on live tags plus older same-cycle grants.
    always_comb begin
        disp_grant_cnt = '0;
        disp_tags      = '0;
        disp_dep_masks = '0;
        granted_all    = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            disp_dep_masks[k] = cur_b_mask | granted_all;
            if (!stall && (k < int'(disp_req_cnt)) && (pick[k] != '0)) begin
                disp_tags[k]   = pick[k];
                granted_all    = granted_all | pick[k];
                disp_grant_cnt = disp_grant_cnt + GW'(1);
            end
        end
    end

    // Next-state: allocation, correct-resolve frees, mispredict squash and recovery FSM.
    always_comb begin
        kill      = '0;
        live_d    = live_q | granted_all;
        dep_d     = dep_q;
        squash_d  = '0;
        restore_d = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;

        for (int t = 0; t < B_MASK_WIDTH; t++) begin
            kill[t] = resolve_tag[t] || ((dep_q[t] & resolve_tag) != '0);
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (disp_tags[k][t]) dep_d[t] = disp_dep_masks[k];
            end
        end

        if (res_hit && !resolve_mispred) begin
            live_d = live_d & ~resolve_tag;
            for (int t = 0; t < B_MASK_WIDTH; t++) dep_d[t] = dep_d[t] & ~resolve_tag;
        end

        if (mispred_hit) begin
            live_d = live_q & ~kill;
            for (int t = 0; t < B_MASK_WIDTH; t++) begin
                dep_d[t] = kill[t] ? '0 : (dep_q[t] & ~kill);
            end
            squash_d  = kill;
            restore_d = 1'b1;
            state_d   = BT_RECOVER;
            cnt_d     = CW'(RECOVER_CYCLES - 1);
        end else if (state_q == BT_RECOVER) begin
            if (cnt_q == '0) state_d = BT_RUN;
            else             cnt_d   = cnt_q - CW'(1);
        end

        free_d = popcnt(~live_d);
    end

    // State register; reset clears everything immediately, with no restore pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            live_q    <= '0;
            dep_q     <= '0;
            squash_q  <= '0;
            restore_q <= 1'b0;
            state_q   <= BT_RUN;
            cnt_q     <= '0;
            free_q    <= FW'(B_MASK_WIDTH);
        end else begin
            live_q    <= live_d;
            dep_q     <= dep_d;
            squash_q  <= squash_d;
            restore_q <= restore_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            free_q    <= free_d;
        end
    end

    assign squash_mask   = squash_q;
    assign restore_valid = restore_q;
    assign recovering    = (state_q == BT_RECOVER);
    assign free_count    = free_q;

`ifdef BTAG_PERF_EN
    logic [31:0] allocs_q, mispreds_q, stalls_q;

    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] inc);
        logic [32:0] s;
        s = {1'b0, v} + {1'b0, inc};
        return s[32] ? '1 : s[31:0];
    endfunction

    // Saturating event counters: tags granted, accepted mispredicts, cycles dispatch was short-changed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            allocs_q   <= '0;
            mispreds_q <= '0;
            stalls_q   <= '0;
        end else begin
            allocs_q   <= sat_add(allocs_q, 32'(disp_grant_cnt));
            mispreds_q <= sat_add(mispreds_q, 32'(mispred_hit));
            stalls_q   <= sat_add(stalls_q, 32'(disp_req_cnt > disp_grant_cnt));
        end
    end

    assign perf_allocs       = allocs_q;
    assign perf_mispreds     = mispreds_q;
    assign perf_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_branch_tag_allocator.sv
// Directed testbench for branch_tag_allocator (default parameters: 4 tags, 2-wide dispatch, 1 recover cycle).
module tb_branch_tag_allocator;
    import sys_defs::*;

    localparam int DW = 2;

    logic              clock;
    logic              reset;
    logic [1:0]        disp_req_cnt;
    logic [1:0]        disp_grant_cnt;
    logic [DW-1:0][3:0] disp_tags;
    logic [DW-1:0][3:0] disp_dep_masks;
    B_MASK             cur_b_mask;
    logic              resolve_valid;
    B_MASK             resolve_tag;
    logic              resolve_mispred;
    B_MASK             b_mm_out;
    B_MASK             squash_mask;
    logic              restore_valid;
    logic              recovering;
    logic [2:0]        free_count;
`ifdef BTAG_PERF_EN
    logic [31:0]       perf_allocs, perf_mispreds, perf_stall_cycles;
`endif

    int total  = 0;
    int passed = 0;

    branch_tag_allocator dut (
        .clock           (clock),
        .reset           (reset),
        .disp_req_cnt    (disp_req_cnt),
        .disp_grant_cnt  (disp_grant_cnt),
        .disp_tags       (disp_tags),
        .disp_dep_masks  (disp_dep_masks),
        .cur_b_mask      (cur_b_mask),
        .resolve_valid   (resolve_valid),
        .resolve_tag     (resolve_tag),
        .resolve_mispred (resolve_mispred),
        .b_mm_out        (b_mm_out),
        .squash_mask     (squash_mask),
        .restore_valid   (restore_valid),
        .recovering      (recovering),
        .free_count      (free_count)
`ifdef BTAG_PERF_EN
        ,
        .perf_allocs       (perf_allocs),
        .perf_mispreds     (perf_mispreds),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        disp_req_cnt    = 2'd0;
        resolve_valid   = 1'b0;
        resolve_tag     = 4'b0000;
        resolve_mispred = 1'b0;
    endtask

    task automatic resolve(input B_MASK tag, input logic mis);
        resolve_valid   = 1'b1;
        resolve_tag     = tag;
        resolve_mispred = mis;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        step();
        step();
        resolve(4'b0001, 1'b0);
        #1;
        total++; if (free_count !== 3'd4) $display("FAIL rst_free got %0d want 4", free_count); else passed++;
        total++; if (cur_b_mask !== 4'b0000) $display("FAIL rst_cur got %b want 0000", cur_b_mask); else passed++;
        total++; if (squash_mask !== 4'b0000) $display("FAIL rst_squash got %b want 0000", squash_mask); else passed++;
        total++; if (restore_valid !== 1'b0) $display("FAIL rst_restore got %b want 0", restore_valid); else passed++;
        total++; if (recovering !== 1'b0) $display("FAIL rst_recovering got %b want 0", recovering); else passed++;
        total++; if (b_mm_out !== 4'b0000) $display("FAIL rst_bmm got %b want 0000", b_mm_out); else passed++;
        total++; if (disp_grant_cnt !== 2'd0) $display("FAIL rst_grant got %0d want 0", disp_grant_cnt); else passed++;
        idle();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_alloc();
        disp_req_cnt = 2'd2;
        #1;
        total++; if (disp_grant_cnt !== 2'd2) $display("FAIL alloc_grant got %0d want 2", disp_grant_cnt); else passed++;
        total++; if (disp_tags[0] !== 4'b0001) $display("FAIL alloc_tag0 got %b want 0001", disp_tags[0]); else passed++;
        total++; if (disp_tags[1] !== 4'b0010) $display("FAIL alloc_tag1 got %b want 0010", disp_tags[1]); else passed++;
        total++; if (disp_dep_masks[0] !== 4'b0000) $display("FAIL alloc_dep0 got %b want 0000", disp_dep_masks[0]); else passed++;
        total++; if (disp_dep_masks[1] !== 4'b0001) $display("FAIL alloc_dep1 got %b want 0001", disp_dep_masks[1]); else passed++;
        step();
        disp_req_cnt = 2'd0;
        #1;
        total++; if (free_count !== 3'd2) $display("FAIL alloc_free got %0d want 2", free_count); else passed++;
        total++; if (cur_b_mask !== 4'b0011) $display("FAIL alloc_cur got %b want 0011", cur_b_mask); else passed++;
        disp_req_cnt = 2'd2;
        #1;
        total++; if (disp_tags[0] !== 4'b0100) $display("FAIL alloc2_tag0 got %b want 0100", disp_tags[0]); else passed++;
        total++; if (disp_tags[1] !== 4'b1000) $display("FAIL alloc2_tag1 got %b want 1000", disp_tags[1]); else passed++;
        total++; if (disp_dep_masks[1] !== 4'b0111) $display("FAIL alloc2_dep1 got %b want 0111", disp_dep_masks[1]); else passed++;
        step();
        idle();
        #1;
        total++; if (free_count !== 3'd0) $display("FAIL alloc2_free got %0d want 0", free_count); else passed++;
        total++; if (cur_b_mask !== 4'b1111) $display("FAIL alloc2_cur got %b want 1111", cur_b_mask); else passed++;
    endtask

    task automatic test_full_and_partial();
        disp_req_cnt = 2'd1;
        resolve(4'b0100, 1'b0);
        #1;
        total++; if (disp_grant_cnt !== 2'd0) $display("FAIL full_grant got %0d want 0", disp_grant_cnt); else passed++;
        total++; if (disp_tags[0] !== 4'b0000) $display("FAIL full_tag0 got %b want 0000", disp_tags[0]); else passed++;
        total++; if (b_mm_out !== 4'b0100) $display("FAIL full_bmm got %b want 0100", b_mm_out); else passed++;
        total++; if (cur_b_mask !== 4'b1011) $display("FAIL full_cur got %b want 1011", cur_b_mask); else passed++;
        step();
        idle();
        disp_req_cnt = 2'd1;
        #1;
        total++; if (free_count !== 3'd1) $display("FAIL regrant_free got %0d want 1", free_count); else passed++;
        total++; if (disp_grant_cnt !== 2'd1) $display("FAIL regrant_grant got %0d want 1", disp_grant_cnt); else passed++;
        total++; if (disp_tags[0] !== 4'b0100) $display("FAIL regrant_tag got %b want 0100", disp_tags[0]); else passed++;
        total++; if (disp_dep_masks[0] !== 4'b1011) $display("FAIL regrant_dep got %b want 1011", disp_dep_masks[0]); else passed++;
        step();
        idle();
        resolve(4'b1000, 1'b0);
        step();
        idle();
        disp_req_cnt = 2'd2;
        #1;
        total++; if (disp_grant_cnt !== 2'd1) $display("FAIL partial_grant got %0d want 1", disp_grant_cnt); else passed++;
        total++; if (disp_tags[0] !== 4'b1000) $display("FAIL partial_tag0 got %b want 1000", disp_tags[0]); else passed++;
        total++; if (disp_tags[1] !== 4'b0000) $display("FAIL partial_tag1 got %b want 0000", disp_tags[1]); else passed++;
        total++; if (disp_dep_masks[0] !== 4'b0111) $display("FAIL partial_dep0 got %b want 0111", disp_dep_masks[0]); else passed++;
        step();
        idle();
    endtask

    task automatic test_mispredict();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        disp_req_cnt = 2'd2;
        step();
        disp_req_cnt = 2'd1;
        #1;
        total++; if (disp_dep_masks[0] !== 4'b0011) $display("FAIL mp_setup_dep got %b want 0011", disp_dep_masks[0]); else passed++;
        step();
        idle();
        disp_req_cnt = 2'd1;
        resolve(4'b0010, 1'b1);
        #1;
        total++; if (disp_grant_cnt !== 2'd0) $display("FAIL mp_cycle_grant got %0d want 0", disp_grant_cnt); else passed++;
        total++; if (b_mm_out !== 4'b0010) $display("FAIL mp_bmm got %b want 0010", b_mm_out); else passed++;
        step();
        resolve_valid   = 1'b0;
        resolve_mispred = 1'b0;
        #1;
        total++; if (squash_mask !== 4'b0110) $display("FAIL mp_squash got %b want 0110", squash_mask); else passed++;
        total++; if (restore_valid !== 1'b1) $display("FAIL mp_restore got %b want 1", restore_valid); else passed++;
        total++; if (recovering !== 1'b1) $display("FAIL mp_recovering got %b want 1", recovering); else passed++;
        total++; if (cur_b_mask !== 4'b0001) $display("FAIL mp_cur got %b want 0001", cur_b_mask); else passed++;
        total++; if (free_count !== 3'd3) $display("FAIL mp_free got %0d want 3", free_count); else passed++;
        total++; if (disp_grant_cnt !== 2'd0) $display("FAIL mp_recover_grant got %0d want 0", disp_grant_cnt); else passed++;
        disp_req_cnt = 2'd0;
        step();
        total++; if (restore_valid !== 1'b0) $display("FAIL mp_restore_end got %b want 0", restore_valid); else passed++;
        total++; if (squash_mask !== 4'b0000) $display("FAIL mp_squash_end got %b want 0000", squash_mask); else passed++;
        total++; if (recovering !== 1'b0) $display("FAIL mp_recover_end got %b want 0", recovering); else passed++;
        disp_req_cnt = 2'd1;
        #1;
        total++; if (disp_tags[0] !== 4'b0010) $display("FAIL mp_post_tag got %b want 0010", disp_tags[0]); else passed++;
        idle();
    endtask

    task automatic test_mispred_in_recover();
        disp_req_cnt = 2'd2;
        step();
        disp_req_cnt = 2'd1;
        #1;
        total++; if (disp_tags[0] !== 4'b1000) $display("FAIL rr_setup_tag got %b want 1000", disp_tags[0]); else passed++;
        step();
        idle();
        resolve(4'b0100, 1'b1);
        step();
        resolve(4'b0010, 1'b1);
        #1;
        total++; if (squash_mask !== 4'b1100) $display("FAIL rr_squash1 got %b want 1100", squash_mask); else passed++;
        total++; if (recovering !== 1'b1) $display("FAIL rr_recovering1 got %b want 1", recovering); else passed++;
        total++; if (b_mm_out !== 4'b0010) $display("FAIL rr_bmm2 got %b want 0010", b_mm_out); else passed++;
        total++; if (cur_b_mask !== 4'b0001) $display("FAIL rr_cur2 got %b want 0001", cur_b_mask); else passed++;
        step();
        idle();
        #1;
        total++; if (squash_mask !== 4'b0010) $display("FAIL rr_squash2 got %b want 0010", squash_mask); else passed++;
        total++; if (restore_valid !== 1'b1) $display("FAIL rr_restore2 got %b want 1", restore_valid); else passed++;
        total++; if (recovering !== 1'b1) $display("FAIL rr_reload got %b want 1", recovering); else passed++;
        total++; if (free_count !== 3'd3) $display("FAIL rr_free got %0d want 3", free_count); else passed++;
        step();
        total++; if (recovering !== 1'b0) $display("FAIL rr_done got %b want 0", recovering); else passed++;
        total++; if (restore_valid !== 1'b0) $display("FAIL rr_restore_end got %b want 0", restore_valid); else passed++;
    endtask

    task automatic test_ignore_resolve();
        resolve(4'b1000, 1'b1);
        disp_req_cnt = 2'd1;
        #1;
        total++; if (b_mm_out !== 4'b0000) $display("FAIL ign_unalloc_bmm got %b want 0000", b_mm_out); else passed++;
        total++; if (disp_grant_cnt !== 2'd1) $display("FAIL ign_unalloc_grant got %0d want 1", disp_grant_cnt); else passed++;
        disp_req_cnt = 2'd0;
        step();
        resolve(4'b0011, 1'b1);
        #1;
        total++; if (b_mm_out !== 4'b0000) $display("FAIL ign_nonhot_bmm got %b want 0000", b_mm_out); else passed++;
        total++; if (recovering !== 1'b0) $display("FAIL ign_unalloc_rec got %b want 0", recovering); else passed++;
        total++; if (squash_mask !== 4'b0000) $display("FAIL ign_unalloc_squash got %b want 0000", squash_mask); else passed++;
        step();
        idle();
        #1;
        total++; if (cur_b_mask !== 4'b0001) $display("FAIL ign_cur got %b want 0001", cur_b_mask); else passed++;
        total++; if (free_count !== 3'd3) $display("FAIL ign_free got %0d want 3", free_count); else passed++;
        total++; if (restore_valid !== 1'b0) $display("FAIL ign_restore got %b want 0", restore_valid); else passed++;
        total++; if (recovering !== 1'b0) $display("FAIL ign_rec got %b want 0", recovering); else passed++;
    endtask

    task automatic test_reset_mid_recover();
        disp_req_cnt = 2'd1;
        step();
        step();
        idle();
        resolve(4'b0100, 1'b1);
        step();
        idle();
        #1;
        total++; if (recovering !== 1'b1) $display("FAIL mrst_pre_rec got %b want 1", recovering); else passed++;
        total++; if (cur_b_mask !== 4'b0011) $display("FAIL mrst_pre_cur got %b want 0011", cur_b_mask); else passed++;
        reset = 1'b0;
        #1;
        total++; if (recovering !== 1'b0) $display("FAIL mrst_rec got %b want 0", recovering); else passed++;
        total++; if (restore_valid !== 1'b0) $display("FAIL mrst_restore got %b want 0", restore_valid); else passed++;
        total++; if (squash_mask !== 4'b0000) $display("FAIL mrst_squash got %b want 0000", squash_mask); else passed++;
        total++; if (free_count !== 3'd4) $display("FAIL mrst_free got %0d want 4", free_count); else passed++;
        total++; if (cur_b_mask !== 4'b0000) $display("FAIL mrst_cur got %b want 0000", cur_b_mask); else passed++;
`ifdef BTAG_PERF_EN
        total++; if (perf_allocs !== 32'd0) $display("FAIL mrst_perf_allocs got %0d want 0", perf_allocs); else passed++;
        total++; if (perf_mispreds !== 32'd0) $display("FAIL mrst_perf_mispreds got %0d want 0", perf_mispreds); else passed++;
        total++; if (perf_stall_cycles !== 32'd0) $display("FAIL mrst_perf_stalls got %0d want 0", perf_stall_cycles); else passed++;
`endif
        step();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #2;
        test_reset();
        test_alloc();
        test_full_and_partial();
        test_mispredict();
        test_mispred_in_recover();
        test_ignore_resolve();
        test_reset_mid_recover();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
